// File: rtl/operand_fetch_seq.sv
// Operand-fetch sequencer: accepts one instruction, walks the register-file reads it needs,
// and presents the A/B operand pair to execute. Optional macro R0_ZERO_EN skips the r0 read for I-type.
module operand_fetch_seq #(
    parameter int DATA_W = 32,
    parameter int C_W    = 19
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              ir_valid,
    output logic              ir_ready,
    input  logic [31:0]       ir,
    output logic [3:0]        sel,
    output logic              sel_en,
    input  logic [DATA_W-1:0] rf_data,
    output logic              ops_valid,
    input  logic              ops_ready,
    output logic [DATA_W-1:0] a_data,
    output logic [DATA_W-1:0] b_data,
    output logic [4:0]        op_code,
    output logic [3:0]        ra_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD1  = 2'd1,
        RD2  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [31:0]       ir_q, ir_nx;
    logic [DATA_W-1:0] a_q, a_nx;
    logic [DATA_W-1:0] b_q, b_nx;
    logic              accept;
    logic              skip_rd;

    function automatic logic [DATA_W-1:0] sext_c(input logic [31:0] word);
        return {{(DATA_W-C_W){word[C_W-1]}}, word[C_W-1:0]};
    endfunction

    // Instructions that need no register-file read go straight from accept to DONE
`ifdef R0_ZERO_EN
    assign skip_rd = (ir[31:30] == 2'b11) || ((ir[31:30] == 2'b00) && (ir[22:19] == 4'd0));
`else
    assign skip_rd = (ir[31:30] == 2'b11);
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_nx;
            ir_q  <= ir_nx;
            a_q   <= a_nx;
            b_q   <= b_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        ir_nx     = ir_q;
        a_nx      = a_q;
        b_nx      = b_q;
        sel       = 4'd0;
        sel_en    = 1'b0;
        ops_valid = 1'b0;
        ir_ready  = 1'b0;
        accept    = 1'b0;

        case (state)
            IDLE: begin
                ir_ready = 1'b1;
            end
            RD1: begin
                sel    = ir_q[22:19];
                sel_en = 1'b1;
                a_nx   = rf_data;
                if ((ir_q[31:30] == 2'b01) || (ir_q[31:30] == 2'b10)) begin
                    state_nx = RD2;
                end else begin
                    state_nx = DONE;
                    b_nx     = sext_c(ir_q);
                end
            end
            RD2: begin
                sel      = (ir_q[31:30] == 2'b01) ? ir_q[18:15] : ir_q[26:23];
                sel_en   = 1'b1;
                b_nx     = rf_data;
                state_nx = DONE;
            end
            DONE: begin
                ops_valid = 1'b1;
                ir_ready  = ops_ready;
                if (ops_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // An accept in DONE retires the old operands on the same edge, so no bubble
        accept = ir_valid && ir_ready;
        if (accept) begin
            ir_nx = ir;
            if (skip_rd) begin
                state_nx = DONE;
                a_nx     = '0;
                b_nx     = (ir[31:30] == 2'b11) ? '0 : sext_c(ir);
            end else begin
                state_nx = RD1;
            end
        end
    end

    assign a_data  = a_q;
    assign b_data  = b_q;
    assign op_code = ir_q[31:27];
    assign ra_idx  = ir_q[26:23];

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Randomized bench for operand_fetch_seq: a cycle-counting transaction model predicts reads,
// latency and operands. Define R0_ZERO_EN here too when the design is built with it.
module tb_operand_fetch_seq;

    logic        clock;
    logic        clear;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir;
    logic [3:0]  sel;
    logic        sel_en;
    logic [31:0] rf_data;
    logic        ops_valid;
    logic        ops_ready;
    logic [31:0] a_data;
    logic [31:0] b_data;
    logic [4:0]  op_code;
    logic [3:0]  ra_idx;

    logic [31:0] rf_mem [16];
    logic        rf_churn;

    int total;
    int bad;

    // Model: one in-flight instruction, how many cycles since it was accepted, and its read list
    logic        busy;
    int          cyc;
    int          nr;
    logic [3:0]  rd_idx [2];
    logic [31:0] rd_val [2];
    logic [31:0] cur_ir;

    operand_fetch_seq #(.DATA_W(32), .C_W(19)) dut (
        .clock     (clock),
        .clear     (clear),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .ir        (ir),
        .sel       (sel),
        .sel_en    (sel_en),
        .rf_data   (rf_data),
        .ops_valid (ops_valid),
        .ops_ready (ops_ready),
        .a_data    (a_data),
        .b_data    (b_data),
        .op_code   (op_code),
        .ra_idx    (ra_idx)
    );

    assign rf_data = rf_mem[sel];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelAccept(input logic [31:0] instr);
        busy   = 1'b1;
        cyc    = 1;
        cur_ir = instr;
        case (instr[31:30])
            2'b00: begin
                nr        = 1;
                rd_idx[0] = instr[22:19];
`ifdef R0_ZERO_EN
                if (instr[22:19] == 4'd0) nr = 0;
`endif
            end
            2'b01: begin
                nr        = 2;
                rd_idx[0] = instr[22:19];
                rd_idx[1] = instr[18:15];
            end
            2'b10: begin
                nr        = 2;
                rd_idx[0] = instr[22:19];
                rd_idx[1] = instr[26:23];
            end
            default: nr = 0;
        endcase
    endtask

    // One clock cycle: check this cycle's outputs, drive new inputs, predict the coming edge
    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic ordy);
        logic        exp_en;
        logic        exp_ov;
        logic        exp_rdy;
        logic [3:0]  exp_sel;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        @(negedge clock);
        if (rf_churn) rf_mem[$urandom_range(0, 15)] = $urandom;
        exp_en  = busy && (cyc <= nr);
        exp_ov  = busy && (cyc >= nr + 1);
        exp_sel = exp_en ? rd_idx[cyc-1] : 4'd0;
        if (exp_en) rd_val[cyc-1] = rf_mem[rd_idx[cyc-1]];
        checkOutput("sel_en", 32'(sel_en), 32'(exp_en));
        checkOutput("sel", 32'(sel), 32'(exp_sel));
        checkOutput("ops_valid", 32'(ops_valid), 32'(exp_ov));
        if (exp_ov) begin
            exp_a = (nr >= 1) ? rd_val[0] : 32'd0;
            case (cur_ir[31:30])
                2'b00:   exp_b = 32'($signed(cur_ir[18:0]));
                2'b11:   exp_b = 32'd0;
                default: exp_b = rd_val[1];
            endcase
            checkOutput("a_data", a_data, exp_a);
            checkOutput("b_data", b_data, exp_b);
            checkOutput("op_code", 32'(op_code), 32'(cur_ir[31:27]));
            checkOutput("ra_idx", 32'(ra_idx), 32'(cur_ir[26:23]));
        end
        ir_valid  = v;
        ir        = instr;
        ops_ready = ordy;
        #1;
        exp_rdy = !busy || (exp_ov && ordy);
        checkOutput("ir_ready", 32'(ir_ready), 32'(exp_rdy));
        if (busy) begin
            if (exp_ov && ordy) busy = 1'b0;
            else cyc++;
        end
        if (v && exp_rdy) modelAccept(instr);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_sel_en"}, 32'(sel_en), 32'd0);
        checkOutput({tag, "_sel"}, 32'(sel), 32'd0);
        checkOutput({tag, "_ops_valid"}, 32'(ops_valid), 32'd0);
        checkOutput({tag, "_a"}, a_data, 32'd0);
        checkOutput({tag, "_b"}, b_data, 32'd0);
        checkOutput({tag, "_op"}, 32'(op_code), 32'd0);
        checkOutput({tag, "_ra"}, 32'(ra_idx), 32'd0);
    endtask

    initial begin
        logic [31:0] rt;
        total     = 0;
        bad       = 0;
        busy      = 1'b0;
        cyc       = 0;
        nr        = 0;
        cur_ir    = '0;
        rf_churn  = 1'b0;
        clear     = 1'b0;
        ir_valid  = 1'b0;
        ir        = '0;
        ops_ready = 1'b0;
        for (int i = 0; i < 16; i++) rf_mem[i] = 32'h100 + i;
        rf_mem[5] = 32'h11;
        rf_mem[9] = 32'h22;
        rf_mem[2] = 32'h5555;
        rf_mem[4] = 32'h44;
        rf_mem[7] = 32'h77;
        #1;
        checkResetOutputs("reset");
        repeat (2) @(negedge clock);
        clear = 1'b1;
        #1;
        checkOutput("ready_after_reset", 32'(ir_ready), 32'd1);

        // Directed: R-type, then backpressure, then chained I-type, store, none-class, rb=0 I-type
        rt = {5'b01000, 4'd3, 4'd5, 4'd9, 15'd0};
        applyStimulus(1'b1, rt, 1'b0);
        repeat (6) applyStimulus(1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, {5'b00010, 4'd1, 4'd2, 19'h7FFFF}, 1'b1);
        repeat (3) applyStimulus(1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, {5'b10001, 4'd7, 4'd4, 19'h0}, 1'b1);
        repeat (4) applyStimulus(1'b0, 32'd0, 1'b1);
        applyStimulus(1'b1, {5'b11111, 4'd6, 4'd8, 19'h12345}, 1'b1);
        repeat (2) applyStimulus(1'b0, 32'd0, 1'b1);
        applyStimulus(1'b1, {5'b00100, 4'd2, 4'd0, 19'h5}, 1'b1);
        repeat (3) applyStimulus(1'b0, 32'd0, 1'b1);

        rf_churn = 1'b1;
        repeat (400) begin
            applyStimulus(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0);
        end

        // Drive an R-type until the model predicts RD2, then pull clear low inside that cycle
        for (int k = 0; k < 20 && !(busy && cyc == 2); k++) begin
            applyStimulus(1'b1, rt, 1'b1);
        end
        checkOutput("reach_rd2", 32'(busy && cyc == 2), 32'd1);
        @(posedge clock);
        #2;
        checkOutput("rd2_sel_en", 32'(sel_en), 32'd1);
        clear    = 1'b0;
        ir_valid = 1'b0;
        #1;
        checkResetOutputs("midreset");
        repeat (3) begin
            @(negedge clock);
            checkOutput("reset_hold_ops_valid", 32'(ops_valid), 32'd0);
        end
        clear = 1'b1;
        busy  = 1'b0;
        #1;
        checkOutput("ready_after_midreset", 32'(ir_ready), 32'd1);

        repeat (150) begin
            applyStimulus(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0);
        end
        repeat (5) applyStimulus(1'b0, 32'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
